div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 153 +++++++++++++++
 tb/tb_div_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequential 32/32 restoring divider (signed/unsigned), 64-bit {rem, quo} result.
// Latency: result_valid 33 cycles after an accepted start (2 cycles for a zero divisor when DIV_ZERO_FAST_EN is defined).
// Backpressure: stall holds the pipeline while busy iterating; start outside IDLE is ignored, cancel aborts to IDLE.
module div_seq (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        sign,
   input  logic        cancel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        stall,
   output logic        busy,
   output logic        result_valid,
   output logic [63:0] result
);

`ifdef DIV_ZERO_FAST_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_ZERO = 2'd2, S_END = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_END = 2'd3} state_t;
`endif

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_div;       // |b|
   logic [31:0] r_rem;       // partial remainder
   logic [31:0] r_quo;       // dividend shifting out, quotient shifting in
   logic        r_qneg;
   logic        r_rneg;

   logic        w_accept;
   logic        w_load;
   logic [31:0] w_a_abs;
   logic [31:0] w_b_abs;
   logic [32:0] w_rem_sh;
   logic        w_ge;
   logic [31:0] w_diff;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_rem_fin;
   logic [31:0] w_quo_fin;
   logic [63:0] w_res_nxt;

   assign w_accept = (r_state == S_IDLE) & start & ~cancel;
   assign w_a_abs  = (sign & a[31]) ? (~a + 32'd1) : a;
   assign w_b_abs  = (sign & b[31]) ? (~b + 32'd1) : b;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   // The 33-bit shifted remainder keeps the compare exact; the difference always fits 32 bits.
   always_comb begin
      w_rem_sh  = {r_rem, r_quo[31]};
      w_ge      = (w_rem_sh >= {1'b0, r_div});
      w_diff    = w_rem_sh[31:0] - r_div;
      w_rem_nxt = w_ge ? w_diff : w_rem_sh[31:0];
      w_quo_nxt = {r_quo[30:0], w_ge};
   end

   // Sign-corrected final value; a zero divisor yields {a, all-ones} because the
   // quotient sign is suppressed at capture and the remainder ends up as |a|.
   always_comb begin
      w_rem_fin = w_rem_nxt;
      w_quo_fin = w_quo_nxt;
`ifdef DIV_ZERO_FAST_EN
      if (r_state == S_ZERO) begin
         w_rem_fin = r_quo;
         w_quo_fin = 32'hFFFF_FFFF;
      end
`endif
      w_res_nxt = {(r_rneg ? (~w_rem_fin + 32'd1) : w_rem_fin),
                   (r_qneg ? (~w_quo_fin + 32'd1) : w_quo_fin)};
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next state and control outputs; cancel overrides everything and blocks the result load.
   always_comb begin
      w_next       = r_state;
      stall        = 1'b0;
      busy         = (r_state != S_IDLE);
      result_valid = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               stall = 1'b1;
`ifdef DIV_ZERO_FAST_EN
               if (b == 32'd0) w_next = S_ZERO;
               else            w_next = S_ON;
`else
               w_next = S_ON;
`endif
            end
         end
         S_ON: begin
            stall = 1'b1;
            if (r_cnt == 5'd31) begin
               w_next = S_END;
               w_load = 1'b1;
            end
         end
`ifdef DIV_ZERO_FAST_EN
         S_ZERO: begin
            stall  = 1'b1;
            w_next = S_END;
            w_load = 1'b1;
         end
`endif
         S_END: begin
            result_valid = ~cancel;
            w_next       = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (cancel) begin
         w_next = S_IDLE;
         w_load = 1'b0;
      end
   end

   // Operand capture on accept, one iteration per ON cycle, result load on completion.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt  <= 5'd0;
         r_div  <= 32'd0;
         r_rem  <= 32'd0;
         r_quo  <= 32'd0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         result <= 64'd0;
      end else begin
         if (w_accept) begin
            r_cnt  <= 5'd0;
            r_div  <= w_b_abs;
            r_rem  <= 32'd0;
            r_quo  <= w_a_abs;
            r_qneg <= sign & (a[31] ^ b[31]) & (b != 32'd0);
            r_rneg <= sign & a[31];
         end else if (r_state == S_ON) begin
            r_cnt <= r_cnt + 5'd1;
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
         end
         if (w_load) result <= w_res_nxt;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with a queue-based scoreboard and a decoupled monitor.
// Latency: expected result and completion cycle are pushed at issue and compared when result_valid appears.
// Backpressure: stall/busy are checked directly around the first operation and the abort scenarios.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        sign;
   logic        cancel;
   logic [31:0] a;
   logic [31:0] b;
   logic        stall;
   logic        busy;
   logic        result_valid;
   logic [63:0] result;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZL = 2;
`else
   localparam int ZL = 33;
`endif

   div_seq dut (
      .clk(clk), .resetn(resetn), .start(start), .sign(sign), .cancel(cancel),
      .a(a), .b(b), .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [63:0] res;
      int          due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] r;
      int          lat;
   } vec_t;
   vec_t vt[10];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every completion pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (resetn === 1'b1 && result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
         end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("latency", 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [63:0] r, input int lat);
      exp_t e;
      start = 1'b1; sign = s; a = aa; b = bb;
      e.res = r;
      e.due = cyc + lat;
      sb.push_back(e);
      tick(1);
      start = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 100) begin
         tick(1);
         k++;
      end
      chk(nm, 64'(sb.size()), 64'd0);
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      vt[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
      vt[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
      vt[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
      vt[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
      vt[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33};
      vt[5] = '{1'b0, 32'h00001234,   32'd0,          64'h00001234_FFFFFFFF, ZL};
      vt[6] = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'hFFFFFFF9_FFFFFFFF, ZL};
      vt[7] = '{1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 33};
      vt[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
      vt[9] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33};

      resetn = 1'b0; start = 1'b0; sign = 1'b0; cancel = 1'b0; a = 32'd0; b = 32'd0;
      tick(2);
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_valid",  64'(result_valid), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_stall",  64'(stall), 64'd0);
      start = 1'b1;
      #1;
      chk("rst_stall_start_term", 64'(stall), 64'd1);
      start = 1'b0;
      resetn = 1'b1;
      tick(1);

      // 100/7 with stall timing around the completion cycle.
      t0 = cyc;
      start = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
      sb.push_back('{64'h00000002_0000000E, t0 + 33});
      #1;
      chk("stall_T", 64'(stall), 64'd1);
      tick(1);
      start = 1'b0;
      tick(31);
      chk("stall_T32", 64'(stall), 64'd1);
      chk("busy_T32",  64'(busy), 64'd1);
      tick(1);
      chk("stall_T33", 64'(stall), 64'd0);
      chk("valid_T33", 64'(result_valid), 64'd1);
      drain("drain_first");

      for (int i = 0; i < 10; i++) begin
         issue(vt[i].s, vt[i].a, vt[i].b, vt[i].r, vt[i].lat);
         drain("drain_vec");
      end

      tick(5);
      chk("result_hold", result, 64'h00000005_00000000);

      // start while busy is ignored: exactly one pulse, original operands.
      issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      tick(4);
      start = 1'b1; a = 32'd1; b = 32'd1;
      tick(1);
      start = 1'b0;
      drain("drain_busy_start");
      tick(3);
      chk("idle_after_ignored_start", 64'(busy), 64'd0);

      // cancel at T+10, restart at T+11.
      t0 = cyc;
      start = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
      tick(1);
      start = 1'b0;
      tick(9);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      chk("cancel_busy",   64'(busy), 64'd0);
      chk("cancel_result", result, 64'h00000002_0000000E);
      chk("cancel_cycle",  64'(cyc), 64'(t0 + 11));
      issue(1'b0, 32'd200, 32'd7, 64'h00000004_0000001C, 33);
      drain("drain_after_cancel");

      // start and cancel together: nothing starts.
      start = 1'b1; cancel = 1'b1; a = 32'd5; b = 32'd1;
      #1;
      chk("start_cancel_stall", 64'(stall), 64'd0);
      tick(1);
      start = 1'b0; cancel = 1'b0;
      chk("start_cancel_busy", 64'(busy), 64'd0);
      tick(40);
      chk("start_cancel_result", result, 64'h00000004_0000001C);

      // reset mid-operation.
      start = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
      tick(1);
      start = 1'b0;
      tick(4);
      resetn = 1'b0;
      #1;
      chk("midrst_busy",   64'(busy), 64'd0);
      chk("midrst_result", result, 64'd0);
      chk("midrst_valid",  64'(result_valid), 64'd0);
      tick(2);
      resetn = 1'b1;
      tick(40);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_result", result, 64'd0);

      issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      drain("drain_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
